// File: rtl/rac_req_arb.sv
// rac_req_arb: shares the single RAC request port between the SPI and OWT
// front-ends, with round-robin or SPI-first arbitration and an ack watchdog.
module rac_req_arb #(
  parameter int REG_AW      = 7,
  parameter int REG_DW      = 8,
  parameter int REG_CRC_W   = 8,
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // SPI requester
  input  logic                 i_spi_wr_req,
  input  logic                 i_spi_rd_req,
  input  logic [REG_AW-1:0]    i_spi_addr,
  input  logic [REG_DW-1:0]    i_spi_wdata,
  input  logic [REG_CRC_W-1:0] i_spi_wcrc,
  output logic                 o_spi_wack,
  output logic                 o_spi_rack,
  output logic [REG_DW-1:0]    o_spi_rdata,
  output logic [REG_AW-1:0]    o_spi_raddr,
  // OWT requester
  input  logic                 i_owt_wr_req,
  input  logic                 i_owt_rd_req,
  input  logic [REG_AW-1:0]    i_owt_addr,
  input  logic [REG_DW-1:0]    i_owt_wdata,
  input  logic [REG_CRC_W-1:0] i_owt_wcrc,
  output logic                 o_owt_wack,
  output logic                 o_owt_rack,
  output logic [REG_DW-1:0]    o_owt_rdata,
  output logic [REG_AW-1:0]    o_owt_raddr,
  // RAC side
  output logic                 o_rac_wr_req,
  output logic                 o_rac_rd_req,
  output logic [REG_AW-1:0]    o_rac_addr,
  output logic [REG_DW-1:0]    o_rac_wdata,
  output logic [REG_CRC_W-1:0] o_rac_wcrc,
  input  logic                 i_rac_wack,
  input  logic                 i_rac_rack,
  input  logic [REG_DW-1:0]    i_rac_rdata,
  input  logic [REG_AW-1:0]    i_rac_raddr,
  // status
  output logic                 o_arb_busy,
  output logic                 o_arb_tmo_err,
  output logic [1:0]           o_dbg_state
);

  // Handshake: requesters hold wr/rd levels until they see a one-cycle ack
  // pulse; the RAC request level is held until a one-cycle ack of the
  // matching type (or the watchdog) ends it. No valid/ready backpressure.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t               state_q;
  logic                 last_gnt_q;  // 1 = OWT held the last grant
  logic                 win_q;       // 1 = OWT owns the current transaction
  logic                 is_wr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 spi_wack_q, spi_rack_q, owt_wack_q, owt_rack_q;
  logic [REG_DW-1:0]    spi_rdata_q, owt_rdata_q;
  logic [REG_AW-1:0]    spi_raddr_q, owt_raddr_q;
  logic                 rac_wr_q, rac_rd_q;
  logic [REG_AW-1:0]    rac_addr_q;
  logic [REG_DW-1:0]    rac_wdata_q;
  logic [REG_CRC_W-1:0] rac_wcrc_q;
  logic                 busy_q, tmo_err_q;

  logic                 spi_pend, owt_pend, pick_owt, sel_wr;
  logic [REG_AW-1:0]    sel_addr;
  logic [REG_DW-1:0]    sel_wdata;
  logic [REG_CRC_W-1:0] sel_wcrc;
  logic                 ack_ok, tmo_hit;

  assign spi_pend = i_spi_wr_req | i_spi_rd_req;
  assign owt_pend = i_owt_wr_req | i_owt_rd_req;

  always_comb begin
    pick_owt = ~spi_pend;
    if ((RR_EN != 0) && spi_pend && owt_pend) pick_owt = ~last_gnt_q;
  end

  // A write wins over a simultaneous read from the same port.
  assign sel_wr    = pick_owt ? i_owt_wr_req : i_spi_wr_req;
  assign sel_addr  = pick_owt ? i_owt_addr   : i_spi_addr;
  assign sel_wdata = pick_owt ? i_owt_wdata  : i_spi_wdata;
  assign sel_wcrc  = pick_owt ? i_owt_wcrc   : i_spi_wcrc;

  assign ack_ok  = is_wr_q ? i_rac_wack : i_rac_rack;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      win_q       <= 1'b0;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      spi_wack_q  <= 1'b0;
      spi_rack_q  <= 1'b0;
      owt_wack_q  <= 1'b0;
      owt_rack_q  <= 1'b0;
      spi_rdata_q <= '0;
      owt_rdata_q <= '0;
      spi_raddr_q <= '0;
      owt_raddr_q <= '0;
      rac_wr_q    <= 1'b0;
      rac_rd_q    <= 1'b0;
      rac_addr_q  <= '0;
      rac_wdata_q <= '0;
      rac_wcrc_q  <= '0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      spi_wack_q <= 1'b0;
      spi_rack_q <= 1'b0;
      owt_wack_q <= 1'b0;
      owt_rack_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (spi_pend || owt_pend) begin
            win_q       <= pick_owt;
            last_gnt_q  <= pick_owt;
            is_wr_q     <= sel_wr;
            rac_wr_q    <= sel_wr;
            rac_rd_q    <= ~sel_wr;
            rac_addr_q  <= sel_addr;
            rac_wdata_q <= sel_wdata;
            rac_wcrc_q  <= sel_wcrc;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_ok || tmo_hit) begin
            rac_wr_q  <= 1'b0;
            rac_rd_q  <= 1'b0;
            tmo_err_q <= ~ack_ok;
            if (win_q) begin
              owt_wack_q <= is_wr_q;
              owt_rack_q <= ~is_wr_q;
            end else begin
              spi_wack_q <= is_wr_q;
              spi_rack_q <= ~is_wr_q;
            end
            // An on-time ack beats the watchdog in the same cycle.
            if (!ack_ok) begin
              if (win_q) owt_rdata_q <= '0;
              else       spi_rdata_q <= '0;
            end else if (!is_wr_q) begin
              if (win_q) begin
                owt_rdata_q <= i_rac_rdata;
                owt_raddr_q <= i_rac_raddr;
              end else begin
                spi_rdata_q <= i_rac_rdata;
                spi_raddr_q <= i_rac_raddr;
              end
            end
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_GAP;
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_spi_wack    = spi_wack_q;
  assign o_spi_rack    = spi_rack_q;
  assign o_spi_rdata   = spi_rdata_q;
  assign o_spi_raddr   = spi_raddr_q;
  assign o_owt_wack    = owt_wack_q;
  assign o_owt_rack    = owt_rack_q;
  assign o_owt_rdata   = owt_rdata_q;
  assign o_owt_raddr   = owt_raddr_q;
  assign o_rac_wr_req  = rac_wr_q;
  assign o_rac_rd_req  = rac_rd_q;
  assign o_rac_addr    = rac_addr_q;
  assign o_rac_wdata   = rac_wdata_q;
  assign o_rac_wcrc    = rac_wcrc_q;
  assign o_arb_busy    = busy_q;
  assign o_arb_tmo_err = tmo_err_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_rac_req_arb.sv
// tb_rac_req_arb: directed vectors and corner-case sequences for rac_req_arb.
// Instance 0 is round-robin, instance 1 is SPI-first; both use an 8-cycle watchdog.
module tb_rac_req_arb;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic          spi_wr, spi_rd, owt_wr, owt_rd, rac_wack, rac_rack;
  logic [AW-1:0] spi_addr, owt_addr, rac_raddr;
  logic [DW-1:0] spi_wdata, owt_wdata, rac_rdata;
  logic [CW-1:0] spi_wcrc, owt_wcrc;

  // per-instance outputs
  logic          spi_wack_a [2], spi_rack_a [2], owt_wack_a [2], owt_rack_a [2];
  logic [DW-1:0] spi_rdata_a [2], owt_rdata_a [2], rac_wdata_a [2];
  logic [AW-1:0] spi_raddr_a [2], owt_raddr_a [2], rac_addr_a [2];
  logic          rac_wr_a [2], rac_rd_a [2], busy_a [2], tmo_a [2];
  logic [CW-1:0] rac_wcrc_a [2];
  logic [1:0]    dbg_a [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rac_req_arb #(
      .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CW),
      .RR_EN((g == 0) ? 1 : 0), .TIMEOUT_CYC(TMO)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_spi_wr_req(spi_wr), .i_spi_rd_req(spi_rd), .i_spi_addr(spi_addr),
      .i_spi_wdata(spi_wdata), .i_spi_wcrc(spi_wcrc),
      .o_spi_wack(spi_wack_a[g]), .o_spi_rack(spi_rack_a[g]),
      .o_spi_rdata(spi_rdata_a[g]), .o_spi_raddr(spi_raddr_a[g]),
      .i_owt_wr_req(owt_wr), .i_owt_rd_req(owt_rd), .i_owt_addr(owt_addr),
      .i_owt_wdata(owt_wdata), .i_owt_wcrc(owt_wcrc),
      .o_owt_wack(owt_wack_a[g]), .o_owt_rack(owt_rack_a[g]),
      .o_owt_rdata(owt_rdata_a[g]), .o_owt_raddr(owt_raddr_a[g]),
      .o_rac_wr_req(rac_wr_a[g]), .o_rac_rd_req(rac_rd_a[g]),
      .o_rac_addr(rac_addr_a[g]), .o_rac_wdata(rac_wdata_a[g]), .o_rac_wcrc(rac_wcrc_a[g]),
      .i_rac_wack(rac_wack), .i_rac_rack(rac_rack),
      .i_rac_rdata(rac_rdata), .i_rac_raddr(rac_raddr),
      .o_arb_busy(busy_a[g]), .o_arb_tmo_err(tmo_a[g]), .o_dbg_state(dbg_a[g])
    );
  end

  // view of the instance under test
  logic          sel;
  logic [3:0]    cur_acks;  // {spi_wack, spi_rack, owt_wack, owt_rack}
  logic          cur_wr, cur_rd, cur_busy, cur_tmo;
  logic [AW-1:0] cur_addr, cur_spi_raddr, cur_owt_raddr;
  logic [DW-1:0] cur_wdata, cur_spi_rdata, cur_owt_rdata;
  logic [CW-1:0] cur_wcrc;
  logic [1:0]    cur_dbg;

  always_comb begin
    cur_acks      = {spi_wack_a[sel], spi_rack_a[sel], owt_wack_a[sel], owt_rack_a[sel]};
    cur_wr        = rac_wr_a[sel];
    cur_rd        = rac_rd_a[sel];
    cur_busy      = busy_a[sel];
    cur_tmo       = tmo_a[sel];
    cur_addr      = rac_addr_a[sel];
    cur_wdata     = rac_wdata_a[sel];
    cur_wcrc      = rac_wcrc_a[sel];
    cur_spi_rdata = spi_rdata_a[sel];
    cur_spi_raddr = spi_raddr_a[sel];
    cur_owt_rdata = owt_rdata_a[sel];
    cur_owt_raddr = owt_raddr_a[sel];
    cur_dbg       = dbg_a[sel];
  end

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] spi_rd_m, owt_rd_m;
  logic [AW-1:0] spi_ra_m, owt_ra_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rdata_all(input string tag);
    check({tag, "_spi_rdata"}, 32'(cur_spi_rdata), 32'(spi_rd_m));
    check({tag, "_spi_raddr"}, 32'(cur_spi_raddr), 32'(spi_ra_m));
    check({tag, "_owt_rdata"}, 32'(cur_owt_rdata), 32'(owt_rd_m));
    check({tag, "_owt_raddr"}, 32'(cur_owt_raddr), 32'(owt_ra_m));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({cur_wr, cur_rd, cur_busy, cur_tmo, cur_acks, cur_dbg}), 32'd0);
    check({tag, "_rac_bus"}, 32'({cur_addr, cur_wdata, cur_wcrc}), 32'd0);
    check({tag, "_rdata_bus"},
          32'({cur_spi_rdata, cur_spi_raddr, cur_owt_rdata, cur_owt_raddr}), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    spi_wr = 0; spi_rd = 0; owt_wr = 0; owt_rd = 0; rac_wack = 0; rac_rack = 0;
    spi_addr = '0; owt_addr = '0; spi_wdata = '0; owt_wdata = '0;
    spi_wcrc = '0; owt_wcrc = '0; rac_rdata = '0; rac_raddr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
    spi_rd_m = '0; owt_rd_m = '0; spi_ra_m = '0; owt_ra_m = '0;
    exp_q.delete();
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(cur_wr || cur_rd) && lat < 40);
    check("req_seen", 32'(cur_wr | cur_rd), 32'd1);
  endtask

  task automatic model_read(input logic port, input logic [AW-1:0] ra);
    logic [DW-1:0] d;
    d = exp_q.pop_front();
    if (port) begin owt_rd_m = d; owt_ra_m = ra; end
    else      begin spi_rd_m = d; spi_ra_m = ra; end
  endtask

  typedef struct {
    logic          port;   // 0 = SPI, 1 = OWT
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] wcrc;
    logic [DW-1:0] rdata;
    logic [AW-1:0] raddr;
    int            dly;    // cycles from request rise to RAC ack
  } vec_t;

  task automatic do_txn(input vec_t v);
    int lat;
    if (v.port) begin
      owt_wr = v.wr; owt_rd = ~v.wr; owt_addr = v.addr; owt_wdata = v.wdata; owt_wcrc = v.wcrc;
    end else begin
      spi_wr = v.wr; spi_rd = ~v.wr; spi_addr = v.addr; spi_wdata = v.wdata; spi_wcrc = v.wcrc;
    end
    wait_req(lat);
    check("grant_latency", 32'(lat), 32'd1);
    check("rac_type", 32'({cur_wr, cur_rd}), 32'({v.wr, ~v.wr}));
    check("rac_addr", 32'(cur_addr), 32'(v.addr));
    check("busy_wait", 32'({cur_busy, cur_dbg}), 32'({1'b1, 2'd1}));
    if (v.wr) begin
      check("rac_wdata", 32'(cur_wdata), 32'(v.wdata));
      check("rac_wcrc", 32'(cur_wcrc), 32'(v.wcrc));
    end else begin
      exp_q.push_back(v.rdata);
    end
    for (int i = 0; i < v.dly; i++) begin
      tick();
      check("req_held", 32'({cur_wr, cur_rd, cur_acks}), 32'({v.wr, ~v.wr, 4'b0000}));
    end
    rac_wack = v.wr; rac_rack = ~v.wr; rac_rdata = v.rdata; rac_raddr = v.raddr;
    tick();
    rac_wack = 0; rac_rack = 0; rac_rdata = ~v.rdata; rac_raddr = ~v.raddr;
    spi_wr = 0; spi_rd = 0; owt_wr = 0; owt_rd = 0;
    if (!v.wr) model_read(v.port, v.raddr);
    check("rac_req_drop", 32'({cur_wr, cur_rd}), 32'd0);
    check("req_ack", 32'(cur_acks),
          32'(v.port ? {2'b00, v.wr, ~v.wr} : {v.wr, ~v.wr, 2'b00}));
    check("no_tmo", 32'(cur_tmo), 32'd0);
    check_rdata_all("resp");
    tick();
    check("gap", 32'({cur_acks, cur_tmo, cur_busy, cur_dbg}), 32'({4'b0, 1'b0, 1'b1, 2'd3}));
    tick();
    check("idle_busy", 32'(cur_busy), 32'd0);
    check_rdata_all("idle");
  endtask

  // ---------------- test ----------------
  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, hi;
    vecs[0] = '{1'b0, 1'b1, 7'h12, 8'hA5, 8'h3C, 8'h00, 7'h00, 2};
    vecs[1] = '{1'b1, 1'b0, 7'h45, 8'h00, 8'h00, 8'h5A, 7'h45, 0};
    vecs[2] = '{1'b0, 1'b0, 7'h7F, 8'h00, 8'h00, 8'hFF, 7'h7F, 3};
    vecs[3] = '{1'b1, 1'b1, 7'h00, 8'h00, 8'hFF, 8'h00, 7'h00, 1};
    vecs[4] = '{1'b0, 1'b0, 7'h01, 8'h00, 8'h00, 8'h81, 7'h01, 6};
    vecs[5] = '{1'b1, 1'b0, 7'h2B, 8'h00, 8'h00, 8'hE7, 7'h2B, TMO - 1};
    vecs[6] = '{1'b0, 1'b1, 7'h7F, 8'hFF, 8'h00, 8'h00, 7'h00, TMO - 1};

    sel = 1'b0;
    clear_inputs();
    do_reset();
    check_all_zero("reset");
    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // round-robin: both ports hold reads from reset
    do_reset();
    spi_rd = 1; spi_addr = 7'h11; owt_rd = 1; owt_addr = 7'h22;
    for (int i = 0; i < 4; i++) begin
      wait_req(lat);
      check("rr_addr", 32'(cur_addr), (i % 2 == 1) ? 32'h22 : 32'h11);
      tick();
      rac_rack = 1; rac_rdata = 8'(8'h30 + i); rac_raddr = (i % 2 == 1) ? 7'h22 : 7'h11;
      exp_q.push_back(8'(8'h30 + i));
      tick();
      rac_rack = 0;
      model_read(i % 2 == 1, (i % 2 == 1) ? 7'h22 : 7'h11);
      check("rr_ack", 32'(cur_acks), (i % 2 == 1) ? 32'h1 : 32'h4);
      check_rdata_all("rr");
    end
    spi_rd = 0; owt_rd = 0;
    repeat (2) tick();

    // fixed priority: SPI always wins until it drops
    sel = 1'b1;
    do_reset();
    spi_rd = 1; spi_addr = 7'h11; owt_rd = 1; owt_addr = 7'h22;
    for (int i = 0; i < 3; i++) begin
      wait_req(lat);
      check("fp_spi_addr", 32'(cur_addr), 32'h11);
      rac_rack = 1; rac_rdata = 8'(8'h40 + i); rac_raddr = 7'h11;
      exp_q.push_back(8'(8'h40 + i));
      tick();
      rac_rack = 0;
      model_read(1'b0, 7'h11);
      check("fp_spi_ack", 32'(cur_acks), 32'h4);
      check_rdata_all("fp");
      if (i == 2) spi_rd = 0;
    end
    wait_req(lat);
    check("fp_owt_lat", 32'(lat), 32'd3);
    check("fp_owt_addr", 32'(cur_addr), 32'h22);
    rac_rack = 1; rac_rdata = 8'h4F; rac_raddr = 7'h22;
    exp_q.push_back(8'h4F);
    tick();
    rac_rack = 0; owt_rd = 0;
    model_read(1'b1, 7'h22);
    check("fp_owt_ack", 32'(cur_acks), 32'h1);
    check_rdata_all("fp_owt");
    repeat (2) tick();

    // watchdog: preload OWT rdata, then a read the RAC never answers
    sel = 1'b0;
    do_reset();
    do_txn('{1'b1, 1'b0, 7'h33, 8'h00, 8'h00, 8'hC3, 7'h33, 0});
    owt_rd = 1; owt_addr = 7'h34;
    wait_req(lat);
    hi = 0;
    while ((cur_wr || cur_rd) && hi < 40) begin
      hi++;
      tick();
    end
    owt_rd = 0;
    owt_rd_m = '0;
    check("wd_req_cycles", 32'(hi), 32'(TMO));
    check("wd_tmo_err", 32'(cur_tmo), 32'd1);
    check("wd_ack", 32'(cur_acks), 32'h1);
    check_rdata_all("wd");
    tick();
    check("wd_tmo_pulse", 32'({cur_tmo, cur_acks}), 32'd0);
    tick();

    // stray wack during an SPI read
    do_reset();
    spi_rd = 1; spi_addr = 7'h55;
    wait_req(lat);
    tick();
    rac_wack = 1;
    tick();
    rac_wack = 0;
    check("stray_held", 32'({cur_wr, cur_rd, cur_acks}), 32'({2'b01, 4'b0000}));
    rac_rack = 1; rac_rdata = 8'h66; rac_raddr = 7'h55;
    exp_q.push_back(8'h66);
    tick();
    rac_rack = 0; spi_rd = 0;
    model_read(1'b0, 7'h55);
    check("stray_ack", 32'({cur_acks, cur_tmo}), 32'({4'h4, 1'b0}));
    check_rdata_all("stray");
    repeat (2) tick();

    // OWT asserts write and read together: write first, then read
    owt_wr = 1; owt_rd = 1; owt_addr = 7'h0A; owt_wdata = 8'h77; owt_wcrc = 8'h88;
    wait_req(lat);
    check("both_first", 32'({cur_wr, cur_rd, cur_wdata, cur_wcrc}), 32'({2'b10, 8'h77, 8'h88}));
    rac_wack = 1;
    tick();
    rac_wack = 0; owt_wr = 0;
    check("both_wack", 32'(cur_acks), 32'h2);
    wait_req(lat);
    check("both_second", 32'({cur_wr, cur_rd}), 32'b01);
    rac_rack = 1; rac_rdata = 8'h99; rac_raddr = 7'h0A;
    exp_q.push_back(8'h99);
    tick();
    rac_rack = 0; owt_rd = 0;
    model_read(1'b1, 7'h0A);
    check("both_rack", 32'(cur_acks), 32'h1);
    check_rdata_all("both");
    repeat (2) tick();

    // reset three cycles into WAIT abandons the transaction
    spi_wr = 1; spi_addr = 7'h01; spi_wdata = 8'hDE; spi_wcrc = 8'hAD;
    wait_req(lat);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    spi_wr = 0;
    rst_n = 1'b1;
    for (int i = 0; i < TMO + 3; i++) begin
      tick();
      check("post_reset_quiet", 32'({cur_acks, cur_tmo, cur_wr, cur_rd}), 32'd0);
    end

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rac_req_arb.md
# rac_req_arb

Two-port arbiter that shares the single register-access-controller (RAC) request port between the SPI slave front-end and the one-wire (OWT) front-end. It accepts level-held write/read requests from each front-end and grants one at a time, round-robin or SPI-first. It forwards the granted command to the RAC, then routes the RAC ack and read data back to the winning requester only. A watchdog aborts any RAC transaction that is never acknowledged, so a hung RAC cannot lock up both host interfaces.

## Interface
- REG_AW, 7, register address width
- REG_DW, 8, register data width
- REG_CRC_W, 8, write CRC width
- RR_EN, 1, 1 = round-robin, 0 = fixed priority (SPI wins)
- TIMEOUT_CYC, 255, RAC ack watchdog in i_clk cycles; 0 = watchdog disabled

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst_n  in  1  synchronous, active-low reset
- i_spi_wr_req / i_spi_rd_req  in  1  SPI request levels, held until acked
- i_spi_addr  in  REG_AW  SPI address
- i_spi_wdata  in  REG_DW  SPI write data
- i_spi_wcrc  in  REG_CRC_W  SPI write CRC
- o_spi_wack / o_spi_rack  out  1  one-cycle ack pulses to SPI
- o_spi_rdata  out  REG_DW  read data returned to SPI
- o_spi_raddr  out  REG_AW  address echo returned to SPI
- i_owt_* / o_owt_*  same set as SPI, for the OWT requester
- o_rac_wr_req / o_rac_rd_req  out  1  request levels to the RAC
- o_rac_addr  out  REG_AW  address to the RAC
- o_rac_wdata  out  REG_DW  write data to the RAC
- o_rac_wcrc  out  REG_CRC_W  write CRC to the RAC
- i_rac_wack / i_rac_rack  in  1  RAC ack pulses
- i_rac_rdata  in  REG_DW  RAC read data
- i_rac_raddr  in  REG_AW  RAC address echo
- o_arb_busy  out  1  high whenever state != IDLE
- o_arb_tmo_err  out  1  one-cycle pulse on watchdog abort

## Operation
- Every output is registered. Reset value of every output is 0.
- Reset also sets state = IDLE and last_gnt = OWT, so the first tie goes to SPI. Timeout counter resets to 0.
- FSM states: IDLE, WAIT, RESP, GAP.
- **IDLE**
  - A port is pending when wr_req | rd_req is high.
  - Winner with RR_EN=1: the pending port not in last_gnt; if only one port is pending, that port.
  - Winner with RR_EN=0: SPI whenever it is pending.
  - If a port asserts both wr and rd, the write is served; the read stays pending.
  - On a grant: latch addr, wdata, wcrc, type and winner id; update last_gnt; go to WAIT.
- **WAIT**
  - o_rac_wr_req or o_rac_rd_req is held high, matching the latched type.
  - An ack of the matching type (wack for a write, rack for a read) completes the transaction:
    - drop the RAC request;
    - for a read, capture i_rac_rdata and i_rac_raddr into the winner's rdata/raddr registers;
    - go to RESP.
  - An ack of the opposite type is ignored.
- **Watchdog (WAIT only)**
  - The counter clears on entry to WAIT and increments each WAIT cycle without a matching ack.
  - If TIMEOUT_CYC cycles pass with no ack: drop the RAC request, pulse o_arb_tmo_err, load the winner's rdata with 0, go to RESP.
  - Counter width is $clog2(TIMEOUT_CYC+1).
  - An ack arriving in the timeout cycle wins; no error is raised.
- **RESP**: the winner's wack or rack is high for exactly this cycle, then go to GAP.
- **GAP**: one idle cycle so the served requester can drop its request level, then go to IDLE.
- rdata/raddr outputs hold their value until the next read response to the same port.
- The non-winning port's outputs never change during another port's transaction.
- RAC acks seen in IDLE, RESP or GAP are ignored.
- A reset mid-transaction abandons the transaction: no ack to the requester, and no tmo_err.

## Timing
- Grant decided in IDLE at cycle c.
  - o_rac_*_req high and o_arb_busy high from c+1.
  - o_rac_addr, wdata and wcrc are valid from c+1 and stable until the next grant.
- Matching ack at cycle k (k ≥ c+1):
  - o_rac_*_req low at k+1;
  - requester ack pulse at k+1;
  - GAP at k+2;
  - IDLE at k+3;
  - next grant's request high at k+4 at the earliest.
- Timeout: the request is high for exactly TIMEOUT_CYC cycles; o_arb_tmo_err and the requester ack are both high in the cycle after the last request-high cycle.
- Minimum spacing between back-to-back grants is 4 cycles.

## Test plan
- **Single write.** SPI write to addr 0x12, data 0xA5, crc 0x3C; RAC wacks 2 cycles after the request rises.
  - o_rac_addr = 0x12, wdata = 0xA5, wcrc = 0x3C.
  - o_spi_wack pulses 1 cycle after the wack.
  - OWT outputs stay 0.
- **Round-robin.** RR_EN=1; SPI and OWT both hold reads from reset; RAC racks each request after 1 cycle.
  - Order is SPI, OWT, SPI, OWT.
  - Each port's rdata equals the i_rac_rdata captured for its own transaction.
- **Fixed priority.** RR_EN=0; both ports continuously request.
  - OWT is never granted while SPI is pending.
  - OWT is granted in the first IDLE cycle where SPI is low.
- **Watchdog.** TIMEOUT_CYC=8; OWT read; RAC never acks.
  - o_rac_rd_req is high for 8 cycles.
  - o_arb_tmo_err and o_owt_rack pulse together; o_owt_rdata = 0.
  - An ack in the 8th cycle gives a normal completion with no error.
- **Robustness.** Stray wack during a read; both wr and rd asserted on one port; reset 3 cycles into WAIT.
  - The stray wack is ignored.
  - The write is served first, then the read.
  - Reset drives all outputs to 0 on the next edge; no ack is issued.
